// File: rtl/icap_pr_arbiter.sv
// Round-robin arbiter between two bitstream sources in front of the ICAP FIFO.
// Holds a grant for a whole bitstream, waits for the ICAP path to drain, then reports done/error.
module icap_pr_arbiter #(
  parameter int DATA_SIZE      = 256,
  parameter int CNT_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DRAIN_CYCLES   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             src_valid,
  input  logic [1:0]             src_last,
  input  logic [2*DATA_SIZE-1:0] src_data,
  output logic [1:0]             src_ready,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic                   fifo_wr_en,
  output logic [DATA_SIZE-1:0]   fifo_din,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   done_id,
  output logic [CNT_WIDTH-1:0]   beat_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN, S_DONE} state_t;

  state_t               state_q;
  logic [1:0]           grant_q;
  logic                 gidx_q;
  logic                 last_winner_q;
  logic [CNT_WIDTH-1:0] beat_q;
  logic [WD_W-1:0]      wdog_q;
  logic [DR_W-1:0]      drain_q;
  logic                 err_q;
  logic                 done_q;
  logic                 error_q;
  logic                 done_id_q;
  logic                 pick_d;

  // Next owner on a request: on a tie the source that did not win last time.
  always_comb begin
    pick_d = 1'b0;
    if (src_valid == 2'b11) begin
      pick_d = ~last_winner_q;
    end else begin
      pick_d = src_valid[1];
    end
  end

  // Pass-through of the granted source onto the FIFO write port while transferring.
  always_comb begin
    src_ready  = 2'b00;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state_q == S_XFER) begin
      src_ready  = gidx_q ? {~fifo_full, 1'b0} : {1'b0, ~fifo_full};
      fifo_wr_en = src_valid[gidx_q] & ~fifo_full;
      fifo_din   = gidx_q ? src_data[2*DATA_SIZE-1:DATA_SIZE] : src_data[DATA_SIZE-1:0];
    end else begin
      src_ready  = 2'b00;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
    end
  end

  // Arbitration / transfer / drain sequencer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 2'b00;
      gidx_q        <= 1'b0;
      last_winner_q <= 1'b1;
      beat_q        <= '0;
      wdog_q        <= '0;
      drain_q       <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      done_id_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|src_valid) begin
            gidx_q  <= pick_d;
            grant_q <= pick_d ? 2'b10 : 2'b01;
            beat_q  <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          drain_q <= '0;
          if (fifo_wr_en) begin
            if (beat_q != {CNT_WIDTH{1'b1}}) begin
              beat_q <= beat_q + CNT_WIDTH'(1);
            end
            wdog_q <= '0;
            if (src_last[gidx_q]) begin
              state_q <= S_DRAIN;
            end
          // A full FIFO is a downstream stall, so only an idle source ages the watchdog.
          end else if (!src_valid[gidx_q] && !fifo_full) begin
            if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
              err_q   <= 1'b1;
              state_q <= S_DRAIN;
            end else begin
              wdog_q <= wdog_q + WD_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            if (drain_q == DR_W'(DRAIN_CYCLES - 1)) begin
              done_q    <= ~err_q;
              error_q   <= err_q;
              done_id_q <= gidx_q;
              state_q   <= S_DONE;
            end else begin
              drain_q <= drain_q + DR_W'(1);
            end
          end else begin
            drain_q <= '0;
          end
        end
        S_DONE: begin
          last_winner_q <= gidx_q;
          grant_q       <= 2'b00;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = error_q;
  assign done_id    = done_id_q;
  assign beat_count = beat_q;

endmodule

// File: tb/tb_icap_pr_arbiter.sv
// Directed self-checking bench for icap_pr_arbiter (TIMEOUT_CYCLES=16, DRAIN_CYCLES=10).
module tb_icap_pr_arbiter;

  localparam int DW = 256;
  localparam int CW = 24;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      src_valid = 2'b00;
  logic [1:0]      src_last = 2'b00;
  logic [DW-1:0]   d0 = '0;
  logic [DW-1:0]   d1 = '0;
  logic [2*DW-1:0] src_data;
  logic            fifo_full = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [1:0]      src_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      grant;
  logic            busy;
  logic            done;
  logic            error;
  logic            done_id;
  logic [CW-1:0]   beat_count;

  int checks = 0;
  int fails  = 0;

  assign src_data = {d1, d0};

  always #5 clock = ~clock;

  icap_pr_arbiter #(
    .DATA_SIZE(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(16), .DRAIN_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_last(src_last),
    .src_data(src_data), .src_ready(src_ready), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant(grant), .busy(busy), .done(done), .error(error), .done_id(done_id),
    .beat_count(beat_count)
  );

  // Bounded wait for a done or error pulse; n = negedges waited, or -1 when the limit expires.
  task automatic wait_done(input int limit, output int n, output logic [1:0] rdy_seen);
    n = -1;
    rdy_seen = 2'b00;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock); #1;
      rdy_seen = rdy_seen | src_ready;
      if (done || error) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || done_id !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: grant=%b busy=%b done=%b error=%b done_id=%b, want 00 0 0 0 0", grant, busy, done, error, done_id);
    end
    checks++;
    if (beat_count !== 24'd0 || src_ready !== 2'b00 || fifo_wr_en !== 1'b0 || fifo_din !== 256'd0) begin
      fails++;
      $display("FAIL reset_datapath: beat_count=%0d src_ready=%b wr_en=%b din=%h, want 0 00 0 0", beat_count, src_ready, fifo_wr_en, fifo_din);
    end
    reset = 1'b1;
  endtask

  task automatic test_single;
    int n;
    logic [1:0] rs;
    @(negedge clock); src_valid = 2'b01; d0 = 256'hA; src_last = 2'b00; #1;
    checks++;
    if (grant !== 2'b00 || fifo_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL single_pre_grant: grant=%b wr_en=%b, want 00 0", grant, fifo_wr_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); d0 = DW'(10 + i); src_last = (i == 3) ? 2'b01 : 2'b00; #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_din !== DW'(10 + i) || grant !== 2'b01 || src_ready !== 2'b01) begin
        fails++;
        $display("FAIL single_beat%0d: wr_en=%b din=%h grant=%b ready=%b, want 1 %h 01 01", i, fifo_wr_en, fifo_din, grant, src_ready, DW'(10 + i));
      end
    end
    @(negedge clock); src_valid = 2'b00; src_last = 2'b00; #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || beat_count !== 24'd4) begin
      fails++;
      $display("FAIL single_drain: wr_en=%b busy=%b beat_count=%0d, want 0 1 4", fifo_wr_en, busy, beat_count);
    end
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || rs !== 2'b00) begin
      fails++;
      $display("FAIL single_done_latency: cycles=%0d ready_seen=%b, want 10 00", n, rs);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || done_id !== 1'b0 || beat_count !== 24'd4) begin
      fails++;
      $display("FAIL single_done: done=%b error=%b id=%b beats=%0d, want 1 0 0 4", done, error, done_id, beat_count);
    end
    @(negedge clock); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || grant !== 2'b00 || beat_count !== 24'd4) begin
      fails++;
      $display("FAIL single_after: done=%b busy=%b grant=%b beats=%0d, want 0 0 00 4", done, busy, grant, beat_count);
    end
  endtask

  task automatic test_round_robin;
    int n;
    logic [1:0] rs;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    src_valid = 2'b11; d0 = 256'h100; d1 = 256'h200; src_last = 2'b11; #1;
    @(negedge clock); #1;
    checks++;
    if (grant !== 2'b01 || src_ready !== 2'b01 || fifo_din !== 256'h100 || fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL rr_first: grant=%b ready=%b din=%h wr_en=%b, want 01 01 100 1", grant, src_ready, fifo_din, fifo_wr_en);
    end
    @(negedge clock); src_valid = 2'b10; #1;
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || rs !== 2'b00 || done_id !== 1'b0) begin
      fails++;
      $display("FAIL rr_first_done: cycles=%0d ready_seen=%b id=%b, want 10 00 0", n, rs, done_id);
    end
    @(negedge clock); src_valid = 2'b11; #1;
    @(negedge clock); #1;
    checks++;
    if (grant !== 2'b10 || src_ready !== 2'b10 || fifo_din !== 256'h200 || fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL rr_second: grant=%b ready=%b din=%h wr_en=%b, want 10 10 200 1", grant, src_ready, fifo_din, fifo_wr_en);
    end
    @(negedge clock); src_valid = 2'b01; #1;
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || done !== 1'b1 || done_id !== 1'b1) begin
      fails++;
      $display("FAIL rr_second_done: cycles=%0d done=%b id=%b, want 10 1 1", n, done, done_id);
    end
    @(negedge clock); src_valid = 2'b11; #1;
    @(negedge clock); #1;
    checks++;
    if (grant !== 2'b01 || fifo_din !== 256'h100) begin
      fails++;
      $display("FAIL rr_third: grant=%b din=%h, want 01 100", grant, fifo_din);
    end
    @(negedge clock); src_valid = 2'b00; src_last = 2'b00; #1;
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || done_id !== 1'b0) begin
      fails++;
      $display("FAIL rr_third_done: cycles=%0d id=%b, want 10 0", n, done_id);
    end
  endtask

  task automatic test_fifo_full;
    int n;
    logic [1:0] rs;
    logic seen_wr, seen_err;
    seen_wr = 1'b0;
    seen_err = 1'b0;
    @(negedge clock); src_valid = 2'b01; d0 = 256'h1; src_last = 2'b00; #1;
    @(negedge clock); #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_din !== 256'h1) begin
      fails++;
      $display("FAIL full_beat1: wr_en=%b din=%h, want 1 1", fifo_wr_en, fifo_din);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); src_valid = 2'b00;
    end
    // 10 source-stall cycles already aged; a full FIFO must freeze that count.
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); fifo_full = 1'b1;
      if (i >= 50) begin
        src_valid = 2'b01; d0 = 256'h2; src_last = 2'b01;
      end
      #1;
      seen_wr = seen_wr | fifo_wr_en | (|src_ready);
      seen_err = seen_err | error | done | ~busy;
    end
    checks++;
    if (seen_wr !== 1'b0 || seen_err !== 1'b0) begin
      fails++;
      $display("FAIL full_stall: write_seen=%b abort_seen=%b, want 0 0", seen_wr, seen_err);
    end
    @(negedge clock); fifo_full = 1'b0; #1;
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_din !== 256'h2 || grant !== 2'b01) begin
      fails++;
      $display("FAIL full_resume: wr_en=%b din=%h grant=%b, want 1 2 01", fifo_wr_en, fifo_din, grant);
    end
    @(negedge clock); src_valid = 2'b00; src_last = 2'b00; #1;
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || done !== 1'b1 || error !== 1'b0 || beat_count !== 24'd2) begin
      fails++;
      $display("FAIL full_done: cycles=%0d done=%b error=%b beats=%0d, want 10 1 0 2", n, done, error, beat_count);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic [1:0] rs;
    @(negedge clock); src_valid = 2'b10; d1 = 256'h31; src_last = 2'b00; #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); d1 = DW'(49 + i); #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_din !== DW'(49 + i)) begin
        fails++;
        $display("FAIL timeout_beat%0d: wr_en=%b din=%h, want 1 %h", i, fifo_wr_en, fifo_din, DW'(49 + i));
      end
    end
    @(negedge clock); src_valid = 2'b00; #1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock); #1;
    end
    checks++;
    if (src_ready !== 2'b10 || grant !== 2'b10) begin
      fails++;
      $display("FAIL timeout_15: ready=%b grant=%b, want 10 10", src_ready, grant);
    end
    @(negedge clock); #1;
    checks++;
    if (src_ready !== 2'b00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL timeout_16: ready=%b busy=%b, want 00 1", src_ready, busy);
    end
    wait_done(40, n, rs);
    checks++;
    if (n !== 10 || error !== 1'b1 || done !== 1'b0 || done_id !== 1'b1 || beat_count !== 24'd3) begin
      fails++;
      $display("FAIL timeout_error: cycles=%0d error=%b done=%b id=%b beats=%0d, want 10 1 0 1 3", n, error, done, done_id, beat_count);
    end
    @(negedge clock); #1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_idle: error=%b busy=%b, want 0 0", error, busy);
    end
  endtask

  task automatic test_drain_toggle;
    int n;
    logic [1:0] rs;
    logic early;
    early = 1'b0;
    @(negedge clock); src_valid = 2'b01; d0 = 256'h55; src_last = 2'b01; #1;
    @(negedge clock); #1;
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      fails++;
      $display("FAIL drain_beat: wr_en=%b, want 1", fifo_wr_en);
    end
    @(negedge clock); src_valid = 2'b00; src_last = 2'b00; #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock); fifo_empty = (k == 7) ? 1'b0 : 1'b1; #1;
      early = early | done | error;
    end
    wait_done(40, n, rs);
    checks++;
    if (early !== 1'b0 || n !== 10 || done !== 1'b1) begin
      fails++;
      $display("FAIL drain_restart: early=%b cycles=%0d done=%b, want 0 10 1", early, n, done);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [1:0] rs;
    logic early;
    early = 1'b0;
    @(negedge clock); src_valid = 2'b10; d1 = 256'h77; src_last = 2'b00; #1;
    @(negedge clock); #1;
    @(negedge clock); d1 = 256'h78; #1;
    @(negedge clock); reset = 1'b0; #1;
    checks++;
    if (grant !== 2'b00 || src_ready !== 2'b00 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || beat_count !== 24'd0) begin
      fails++;
      $display("FAIL rstmid_clear: grant=%b ready=%b wr_en=%b busy=%b beats=%0d, want 00 00 0 0 0", grant, src_ready, fifo_wr_en, busy, beat_count);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock); #1;
      early = early | done | error;
    end
    @(negedge clock); reset = 1'b1; src_valid = 2'b01; d0 = 256'h99; src_last = 2'b01; #1;
    @(negedge clock); #1;
    checks++;
    if (grant !== 2'b01 || fifo_wr_en !== 1'b1 || fifo_din !== 256'h99) begin
      fails++;
      $display("FAIL rstmid_regrant: grant=%b wr_en=%b din=%h, want 01 1 99", grant, fifo_wr_en, fifo_din);
    end
    @(negedge clock); src_valid = 2'b00; src_last = 2'b00; #1;
    wait_done(40, n, rs);
    checks++;
    if (early !== 1'b0 || n !== 10 || done !== 1'b1 || done_id !== 1'b0 || beat_count !== 24'd1) begin
      fails++;
      $display("FAIL rstmid_done: early=%b cycles=%0d done=%b id=%b beats=%0d, want 0 10 1 0 1", early, n, done, done_id, beat_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_timeout();
    test_drain_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
